// File: rtl/sram_like_axi_bridge.sv
// Single-outstanding bridge from the instruction/data SRAM-like masters to one AXI master port.
// Data side wins arbitration; every grant becomes exactly one single-beat AXI transaction.
module sram_like_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

  // Byte lanes follow the natural SRAM-like placement; size 3 is treated as a word.
  function automatic logic [3:0] calc_wstrb(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << lane;
      2'd1:    strb = 4'b0011 << {lane[1], 1'b0};
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  state_t      state_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [1:0]  size_r;
  logic [3:0]  id_r;
  logic [3:0]  wstrb_r;
  logic        src_r;
  logic        arvalid_r;
  logic        rready_r;
  logic        awvalid_r;
  logic        wvalid_r;
  logic        bready_r;
  logic        aw_done_r;
  logic        w_done_r;
  logic        data_grant_s;
  logic        inst_grant_s;
  logic        aw_done_next_s;
  logic        w_done_next_s;
  logic        rd_hit_s;
  logic        wr_hit_s;
  logic        unused_inputs_s;

  assign unused_inputs_s = ^{inst_wr, rid};
  assign aw_done_next_s  = aw_done_r | (awvalid_r & awready);
  assign w_done_next_s   = w_done_r | (wvalid_r & wready);

  // Fixed priority grant, only while idle and out of reset.
  always_comb begin
    data_grant_s = 1'b0;
    inst_grant_s = 1'b0;
    if (rst && (state_r == IDLE)) begin
      if (data_req) begin
        data_grant_s = 1'b1;
      end else if (inst_req) begin
        inst_grant_s = 1'b1;
      end else begin
        inst_grant_s = 1'b0;
      end
    end else begin
      data_grant_s = 1'b0;
    end
  end

  // Transaction FSM with registered AXI valid/ready outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      addr_r    <= 32'd0;
      wdata_r   <= 32'd0;
      size_r    <= 2'd0;
      id_r      <= 4'd0;
      wstrb_r   <= 4'd0;
      src_r     <= 1'b0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (data_grant_s) begin
            addr_r  <= data_addr;
            wdata_r <= data_wdata;
            size_r  <= data_size;
            id_r    <= DATA_ID;
            wstrb_r <= calc_wstrb(data_size, data_addr[1:0]);
            src_r   <= 1'b1;
            if (data_wr) begin
              state_r   <= WR_REQ;
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
            end else begin
              state_r   <= RD_ADDR;
              arvalid_r <= 1'b1;
            end
          end else if (inst_grant_s) begin
            addr_r    <= inst_addr;
            wdata_r   <= inst_wdata;
            size_r    <= inst_size;
            id_r      <= INST_ID;
            wstrb_r   <= calc_wstrb(inst_size, inst_addr[1:0]);
            src_r     <= 1'b0;
            state_r   <= RD_ADDR;
            arvalid_r <= 1'b1;
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rready_r <= 1'b0;
            state_r  <= IDLE;
          end
        end
        WR_REQ: begin
          // Address and data channels retire independently, in either order.
          awvalid_r <= awvalid_r & ~awready;
          wvalid_r  <= wvalid_r & ~wready;
          if (aw_done_next_s && w_done_next_s) begin
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            bready_r  <= 1'b1;
            state_r   <= WR_RESP;
          end else begin
            aw_done_r <= aw_done_next_s;
            w_done_r  <= w_done_next_s;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready_r <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          arvalid_r <= 1'b0;
          rready_r  <= 1'b0;
          awvalid_r <= 1'b0;
          wvalid_r  <= 1'b0;
          bready_r  <= 1'b0;
        end
      endcase
    end
  end

  // Completion handshakes and read data steering to the latched source.
  always_comb begin
    rd_hit_s     = rst & rready_r & rvalid;
    wr_hit_s     = rst & bready_r & bvalid;
    inst_data_ok = rd_hit_s & ~src_r;
    data_data_ok = (rd_hit_s & src_r) | wr_hit_s;
    if (inst_data_ok) begin
      inst_rdata = rdata;
    end else begin
      inst_rdata = 32'd0;
    end
    if (rd_hit_s && src_r) begin
      data_rdata = rdata;
    end else begin
      data_rdata = 32'd0;
    end
  end

  assign inst_addr_ok = inst_grant_s;
  assign data_addr_ok = data_grant_s;

  assign arid    = id_r;
  assign araddr  = addr_r;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_r};
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = arvalid_r;
  assign rready  = rready_r;

  assign awid    = id_r;
  assign awaddr  = addr_r;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, size_r};
  assign awburst = 2'b01;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = awvalid_r;
  assign wdata   = wdata_r;
  assign wstrb   = wstrb_r;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_r;
  assign bready  = bready_r;

endmodule

// File: tb/tb_sram_like_axi_bridge.sv
// Bench for sram_like_axi_bridge: delay-programmable AXI slave, posedge monitor and
// per-scenario tasks comparing against expectations derived from the access rules.
module tb_sram_like_axi_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [3:0]  arid, awid, arcache, awcache, rid, wstrb;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock;
  logic        arvalid, arready, rvalid, rready, awvalid, awready;
  logic        wlast, wvalid, wready, bvalid, bready;

  int total = 0;
  int bad = 0;

  // slave configuration and observations
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] rd_val = 32'd0;
  bit spurious = 1'b0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  bit r_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0;
  logic [31:0] ar_addr_seen = 32'd0, aw_addr_seen = 32'd0, w_data_seen = 32'd0;
  logic [2:0]  ar_size_seen = 3'd0, aw_size_seen = 3'd0;
  logic [3:0]  ar_id_seen = 4'd0, aw_id_seen = 4'd0, w_strb_seen = 4'd0;
  int n_ar = 0, n_aw = 0, n_w = 0;

  // monitor counters
  int n_iaok = 0, n_daok = 0, n_idok = 0, n_ddok = 0, n_overlap = 0;
  int n_arv = 0, n_awv = 0, n_wv = 0, n_unstable = 0, n_busy_aok = 0;
  logic prev_arv = 1'b0;
  logic [31:0] prev_araddr = 32'd0;

  sram_like_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  assign rid = 4'd0;

  // AXI slave: decides at negedge what to present at the following posedge
  always @(negedge clk) begin
    if (!rst) begin
      arready <= 1'b0; rvalid <= 1'b0; awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0;
      rdata <= 32'd0; ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      r_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
    end else if (spurious) begin
      rvalid <= 1'b1; bvalid <= 1'b1; rdata <= 32'hDEADBEEF;
      arready <= 1'b0; awready <= 1'b0; wready <= 1'b0;
    end else begin
      if (arvalid && !arready) begin
        if (ar_cnt == ar_dly) begin
          arready <= 1'b1; ar_cnt <= 0; n_ar <= n_ar + 1;
          ar_addr_seen <= araddr; ar_size_seen <= arsize; ar_id_seen <= arid;
          r_pend <= 1'b1; r_cnt <= 0;
        end else ar_cnt <= ar_cnt + 1;
      end else begin
        arready <= 1'b0; ar_cnt <= 0;
      end
      if (rvalid) rvalid <= 1'b0;
      else if (rready && r_pend) begin
        if (r_cnt == r_dly) begin
          rvalid <= 1'b1; rdata <= rd_val; r_pend <= 1'b0;
        end else r_cnt <= r_cnt + 1;
      end
      if (awvalid && !awready) begin
        if (aw_cnt == aw_dly) begin
          awready <= 1'b1; aw_cnt <= 0; n_aw <= n_aw + 1; aw_got <= 1'b1;
          aw_addr_seen <= awaddr; aw_size_seen <= awsize; aw_id_seen <= awid;
        end else aw_cnt <= aw_cnt + 1;
      end else begin
        awready <= 1'b0; aw_cnt <= 0;
      end
      if (wvalid && !wready) begin
        if (w_cnt == w_dly) begin
          wready <= 1'b1; w_cnt <= 0; n_w <= n_w + 1; w_got <= 1'b1;
          w_data_seen <= wdata; w_strb_seen <= wstrb;
        end else w_cnt <= w_cnt + 1;
      end else begin
        wready <= 1'b0; w_cnt <= 0;
      end
      if (bvalid) bvalid <= 1'b0;
      else if (bready && aw_got && w_got) begin
        if (b_cnt == b_dly) begin
          bvalid <= 1'b1; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
        end else b_cnt <= b_cnt + 1;
      end
    end
  end

  // Cycle monitor sampling settled values at each active edge
  always @(posedge clk) begin
    if (inst_addr_ok) n_iaok <= n_iaok + 1;
    if (data_addr_ok) n_daok <= n_daok + 1;
    if (inst_data_ok) n_idok <= n_idok + 1;
    if (data_data_ok) n_ddok <= n_ddok + 1;
    if ((inst_addr_ok && inst_data_ok) || (data_addr_ok && data_data_ok)) n_overlap <= n_overlap + 1;
    if (arvalid) n_arv <= n_arv + 1;
    if (awvalid) n_awv <= n_awv + 1;
    if (wvalid) n_wv <= n_wv + 1;
    if (arvalid && prev_arv && (araddr !== prev_araddr)) n_unstable <= n_unstable + 1;
    if ((inst_addr_ok || data_addr_ok) && (arvalid || rready || awvalid || wvalid || bready))
      n_busy_aok <= n_busy_aok + 1;
    prev_arv <= arvalid;
    prev_araddr <= araddr;
  end

  // Reference byte-lane rule: an access of 2^size bytes (word for size>=2) on its aligned lanes.
  function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [31:0] addr);
    logic [3:0] s;
    int nb, base;
    nb = (size >= 2'd2) ? 4 : (1 << size);
    base = (int'(addr[1:0]) / nb) * nb;
    for (int lane = 0; lane < 4; lane++) s[lane] = (lane >= base) && (lane < base + nb);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Stimulus only: present one request, scramble it after grant unless held, await completion.
  task automatic issue(input bit is_data, input bit wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wd, input bit hold,
                       output bit got_aok, output bit got_dok, output int lat,
                       output logic [31:0] rd);
    got_aok = 1'b0; got_dok = 1'b0; lat = 0; rd = 32'd0;
    if (is_data) begin
      data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
    end else begin
      inst_req = 1'b1; inst_wr = wr; inst_size = size; inst_addr = addr; inst_wdata = wd;
    end
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); #1;
      if (is_data ? data_addr_ok : inst_addr_ok) begin
        got_aok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    if (!hold) begin
      if (is_data) begin
        data_req = 1'b0; data_wr = 1'($urandom); data_size = 2'($urandom);
        data_addr = $urandom; data_wdata = $urandom;
      end else begin
        inst_req = 1'b0; inst_wr = 1'($urandom); inst_size = 2'($urandom);
        inst_addr = $urandom; inst_wdata = $urandom;
      end
    end
    if (got_aok) begin
      for (int k = 1; k < 100; k++) begin
        @(negedge clk); #1;
        if (is_data ? data_data_ok : inst_data_ok) begin
          got_dok = 1'b1; lat = k; rd = is_data ? data_rdata : inst_rdata;
          break;
        end
        tick();
      end
    end
    tick();
  endtask

  task automatic test_reset();
    inst_req = 1'b1; inst_addr = 32'h1234_5678; inst_size = 2'd2;
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk); #1;
    total++;
    if ({arvalid, rready, awvalid, wvalid, bready, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 9'd0) begin
      bad++; $display("FAIL reset_ctrl got %b want 0", {arvalid, rready, awvalid, wvalid, bready, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
    end
    total++;
    if ({araddr, awaddr, wdata} !== 96'd0) begin
      bad++; $display("FAIL reset_addr_data got %h want 0", {araddr, awaddr, wdata});
    end
    total++;
    if ({arid, awid, wstrb} !== 12'd0) begin
      bad++; $display("FAIL reset_id_strb got %h want 0", {arid, awid, wstrb});
    end
    tick();
    inst_req = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_inst_read();
    bit a, d; int lat; logic [31:0] rd;
    ar_dly = 0; r_dly = 0; rd_val = 32'h3C08_0001;
    issue(1'b0, 1'b1, 2'd2, 32'hBFC0_0000, 32'h0, 1'b0, a, d, lat, rd);
    total++;
    if ({a, d} !== 2'b11 || lat !== 2) begin
      bad++; $display("FAIL inst_read_latency got aok=%0d dok=%0d lat=%0d want 1 1 2", a, d, lat);
    end
    total++;
    if (rd !== 32'h3C08_0001) begin
      bad++; $display("FAIL inst_read_data got %h want 3c080001", rd);
    end
    total++;
    if ({ar_addr_seen, ar_size_seen, ar_id_seen} !== {32'hBFC0_0000, 3'b010, 4'd0}) begin
      bad++; $display("FAIL inst_read_ar got %h/%0d/%0d want bfc00000/2/0", ar_addr_seen, ar_size_seen, ar_id_seen);
    end
  endtask

  task automatic test_contention();
    bit a, d, ok2; int lat, n0; logic [31:0] rd;
    ar_dly = 0; r_dly = 0; rd_val = 32'h5555_AAAA;
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h0000_0100;
    n0 = n_iaok;
    issue(1'b1, 1'b0, 2'd2, 32'h8000_1000, 32'h0, 1'b0, a, d, lat, rd);
    total++;
    if ({a, d} !== 2'b11 || rd !== 32'h5555_AAAA || ar_id_seen !== 4'd1 || ar_addr_seen !== 32'h8000_1000) begin
      bad++; $display("FAIL contention_data got aok=%0d dok=%0d rd=%h id=%0d addr=%h want 1 1 5555aaaa 1 80001000", a, d, rd, ar_id_seen, ar_addr_seen);
    end
    total++;
    if (n_iaok !== n0) begin
      bad++; $display("FAIL contention_inst_early got %0d inst grants want 0", n_iaok - n0);
    end
    rd_val = 32'h0BAD_F00D;
    @(negedge clk); #1;
    total++;
    if (inst_addr_ok !== 1'b1) begin
      bad++; $display("FAIL contention_inst_next got %b want 1", inst_addr_ok);
    end
    tick();
    inst_req = 1'b0;
    ok2 = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); #1;
      if (inst_data_ok) begin
        ok2 = 1'b1; rd = inst_rdata;
        break;
      end
      tick();
    end
    tick();
    total++;
    if (!ok2 || rd !== 32'h0BAD_F00D || ar_id_seen !== 4'd0 || ar_addr_seen !== 32'h0000_0100) begin
      bad++; $display("FAIL contention_inst_read got dok=%0d rd=%h id=%0d addr=%h want 1 0badf00d 0 00000100", ok2, rd, ar_id_seen, ar_addr_seen);
    end
  endtask

  task automatic test_byte_store();
    bit a, d; int lat, n0; logic [31:0] rd;
    aw_dly = 1; w_dly = 0; b_dly = 2;
    n0 = n_ddok;
    issue(1'b1, 1'b1, 2'd0, 32'h8000_0003, 32'hAA00_0000, 1'b0, a, d, lat, rd);
    total++;
    if ({aw_addr_seen, aw_size_seen, aw_id_seen} !== {32'h8000_0003, 3'd0, 4'd1}) begin
      bad++; $display("FAIL byte_store_aw got %h/%0d/%0d want 80000003/0/1", aw_addr_seen, aw_size_seen, aw_id_seen);
    end
    total++;
    if ({w_data_seen, w_strb_seen} !== {32'hAA00_0000, 4'b1000}) begin
      bad++; $display("FAIL byte_store_w got %h/%b want aa000000/1000", w_data_seen, w_strb_seen);
    end
    total++;
    if ({a, d} !== 2'b11 || lat !== 5 || n_ddok - n0 !== 1) begin
      bad++; $display("FAIL byte_store_ok got dok=%0d lat=%0d pulses=%0d want 1 5 1", d, lat, n_ddok - n0);
    end
  endtask

  task automatic test_write_orders();
    int aws[3] = '{3, 0, 2};
    int ws[3]  = '{0, 3, 2};
    bit a, d; int lat, naw0, nw0, nawv0, nwv0, nd0; logic [31:0] rd, wd;
    b_dly = 0;
    for (int i = 0; i < 3; i++) begin
      aw_dly = aws[i]; w_dly = ws[i];
      naw0 = n_aw; nw0 = n_w; nawv0 = n_awv; nwv0 = n_wv; nd0 = n_ddok;
      wd = $urandom;
      issue(1'b1, 1'b1, 2'd2, {$urandom} & 32'hFFFF_FFFC, wd, 1'b0, a, d, lat, rd);
      total++;
      if (n_aw - naw0 !== 1 || n_w - nw0 !== 1) begin
        bad++; $display("FAIL wr_order%0d_beats got aw=%0d w=%0d want 1 1", i, n_aw - naw0, n_w - nw0);
      end
      total++;
      if (n_awv - nawv0 !== aws[i] + 1 || n_wv - nwv0 !== ws[i] + 1) begin
        bad++; $display("FAIL wr_order%0d_valid_cycles got aw=%0d w=%0d want %0d %0d", i, n_awv - nawv0, n_wv - nwv0, aws[i] + 1, ws[i] + 1);
      end
      total++;
      if (n_ddok - nd0 !== 1 || !d || lat !== 2 + ((aws[i] > ws[i]) ? aws[i] : ws[i])) begin
        bad++; $display("FAIL wr_order%0d_ok got pulses=%0d lat=%0d", i, n_ddok - nd0, lat);
      end
      total++;
      if ({w_data_seen, w_strb_seen} !== {wd, 4'b1111}) begin
        bad++; $display("FAIL wr_order%0d_w got %h/%b want %h/1111", i, w_data_seen, w_strb_seen, wd);
      end
    end
  endtask

  task automatic test_stalls();
    bit a, d; int lat, na0, narv0; logic [31:0] rd;
    ar_dly = 5; r_dly = 4; rd_val = 32'hCAFE_0042;
    na0 = n_daok; narv0 = n_arv;
    issue(1'b1, 1'b0, 2'd1, 32'h8000_2002, 32'h0, 1'b1, a, d, lat, rd);
    data_req = 1'b0;
    total++;
    if (!d || lat !== 11 || rd !== 32'hCAFE_0042) begin
      bad++; $display("FAIL stall_read got dok=%0d lat=%0d rd=%h want 1 11 cafe0042", d, lat, rd);
    end
    total++;
    if (n_daok - na0 !== 1 || n_busy_aok !== 0) begin
      bad++; $display("FAIL stall_extra_grant got grants=%0d busy=%0d want 1 0", n_daok - na0, n_busy_aok);
    end
    total++;
    if (n_arv - narv0 !== 6 || n_unstable !== 0 || ar_addr_seen !== 32'h8000_2002 || ar_size_seen !== 3'd1) begin
      bad++; $display("FAIL stall_ar got cycles=%0d unstable=%0d addr=%h size=%0d want 6 0 80002002 1", n_arv - narv0, n_unstable, ar_addr_seen, ar_size_seen);
    end
  endtask

  task automatic test_spurious();
    int hits = 0;
    spurious = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (rready || bready || inst_data_ok || data_data_ok) hits++;
      tick();
    end
    spurious = 1'b0;
    repeat (2) tick();
    total++;
    if (hits !== 0) begin
      bad++; $display("FAIL spurious_response got %0d reacting cycles want 0", hits);
    end
  endtask

  task automatic test_reset_mid_read();
    bit a, d, in_rd; int lat; logic [31:0] rd;
    ar_dly = 0; r_dly = 20;
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'hBFC0_0100;
    in_rd = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      inst_req = 1'b0;
      if (rready) begin
        in_rd = 1'b1;
        break;
      end
    end
    rst = 1'b0;
    tick();
    @(negedge clk); #1;
    total++;
    if (!in_rd || {arvalid, rready, awvalid, wvalid, bready, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 9'd0 || araddr !== 32'd0) begin
      bad++; $display("FAIL reset_mid_read got reached=%0d ctrl=%b araddr=%h want 1 0 0", in_rd, {arvalid, rready, awvalid, wvalid, bready, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, araddr);
    end
    tick();
    rst = 1'b1;
    r_dly = 0; rd_val = 32'h2408_0007;
    issue(1'b0, 1'b0, 2'd2, 32'hBFC0_0004, 32'h0, 1'b0, a, d, lat, rd);
    total++;
    if ({a, d} !== 2'b11 || lat !== 2 || rd !== 32'h2408_0007) begin
      bad++; $display("FAIL after_reset_read got dok=%0d lat=%0d rd=%h want 1 2 24080007", d, lat, rd);
    end
  endtask

  task automatic test_random();
    bit is_data, wr, a, d; int lat, exp_lat; logic [1:0] size; logic [31:0] addr, wd, rd;
    for (int i = 0; i < 40; i++) begin
      is_data = 1'($urandom); wr = is_data & 1'($urandom);
      size = 2'($urandom); addr = $urandom; wd = $urandom; rd_val = $urandom;
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      exp_lat = wr ? 2 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly : 2 + ar_dly + r_dly;
      issue(is_data, wr, size, addr, wd, 1'b0, a, d, lat, rd);
      total++;
      if ({a, d} !== 2'b11 || lat !== exp_lat) begin
        bad++; $display("FAIL rand%0d_timing got aok=%0d dok=%0d lat=%0d want 1 1 %0d", i, a, d, lat, exp_lat);
      end
      total++;
      if (wr) begin
        if ({aw_addr_seen, aw_size_seen, aw_id_seen, w_data_seen, w_strb_seen} !== {addr, 1'b0, size, 4'd1, wd, model_strb(size, addr)}) begin
          bad++; $display("FAIL rand%0d_write got %h/%0d/%0d/%h/%b want %h/%0d/1/%h/%b", i, aw_addr_seen, aw_size_seen, aw_id_seen, w_data_seen, w_strb_seen, addr, size, wd, model_strb(size, addr));
        end
      end else begin
        if ({ar_addr_seen, ar_size_seen, ar_id_seen, rd} !== {addr, 1'b0, size, 3'd0, is_data, rd_val}) begin
          bad++; $display("FAIL rand%0d_read got %h/%0d/%0d/%h want %h/%0d/%0d/%h", i, ar_addr_seen, ar_size_seen, ar_id_seen, rd, addr, size, is_data, rd_val);
        end
      end
    end
  endtask

  task automatic test_invariants();
    total++;
    if (n_overlap !== 0 || n_unstable !== 0) begin
      bad++; $display("FAIL invariants got overlap=%0d unstable=%0d want 0 0", n_overlap, n_unstable);
    end
  endtask

  initial begin
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = 32'd0; inst_wdata = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
    test_reset();
    test_inst_read();
    test_contention();
    test_byte_store();
    test_write_orders();
    test_stalls();
    test_spurious();
    test_reset_mid_read();
    test_random();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_like_axi_bridge.md
Name: sram_like_axi_bridge

Overview:
- Single-outstanding bridge between the two SRAM-like masters (instruction side, data side) and one AXI3/AXI4 master port toward the SoC crossbar.
- Sits directly downstream of the instruction and data SRAM-to-SRAM-like converters.
- Arbitrates between the two masters, issues one single-beat AXI transaction at a time, and returns addr_ok/data_ok handshakes to the winning master.

Parameters:
- INST_ID, 4'd0, ARID used for instruction reads.
- DATA_ID, 4'd1, ARID/AWID used for data accesses.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- inst_req / inst_wr / inst_size / inst_addr / inst_wdata  in  1/1/2/32/32  SRAM-like request, instruction side. inst_wr is ignored; instruction accesses are always reads.
- inst_rdata  out  32  read data, valid when inst_data_ok=1.
- inst_addr_ok / inst_data_ok  out  1/1  SRAM-like handshakes, instruction side.
- data_req / data_wr / data_size / data_addr / data_wdata  in  1/1/2/32/32  SRAM-like request, data side.
- data_rdata  out  32  read data, valid when data_data_ok=1.
- data_addr_ok / data_data_ok  out  1/1  SRAM-like handshakes, data side.
- arid / araddr / arsize / arvalid  out  4/32/3/1  AXI read address; arready in 1.
- rid / rdata / rvalid  in  4/32/1  AXI read data; rready out 1.
- awid / awaddr / awsize / awvalid  out  4/32/3/1  AXI write address; awready in 1.
- wdata / wstrb / wvalid  out  32/4/1  AXI write data; wready in 1.
- bvalid  in  1  write response; bready out 1.
- Top level ties arlen/awlen=0, burst=INCR, lock/cache/prot=0, wlast=1, and awid equal to arid.

Behaviour:
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. Reset state is IDLE.
- Reset values: all valid/ready/ok outputs are 0; registered address, data and ID are 0.

IDLE arbitration:
- data_req has priority over inst_req.
- The winner receives addr_ok=1 combinationally in the same cycle; the loser's addr_ok is 0.
- No addr_ok is asserted in any state other than IDLE.
- On grant, latch addr, size, wdata, wr and source (inst/data).
- Next state is RD_ADDR if the access is a read, WR_REQ if it is a write (data side only).

Read path:
- RD_ADDR: arvalid=1; araddr/arsize/arid come from latches.
- arsize = {1'b0, size}.
- On arready, go to RD_DATA.
- RD_DATA: rready=1. When rvalid=1:
  - Pulse data_ok=1 for one cycle to the latched source only.
  - Drive <src>_rdata = rdata combinationally in that cycle.
  - Return to IDLE.
- rid is not checked.

Write path:
- WR_REQ: awvalid and wvalid are both asserted at entry.
- Each valid drops independently after its own ready is seen, tracked by aw_done and w_done.
- Handle awready and wready in the same or different cycles; both orders must work.
- When both are done, go to WR_RESP.
- WR_RESP: bready=1. On bvalid, pulse data_data_ok for one cycle and return to IDLE.

wstrb (from latched size and addr[1:0]):
- size 0: 4'b0001 << addr[1:0].
- size 1: 4'b0011 << {addr[1], 1'b0}.
- size 2: 4'b1111.
- size 3: reserved; treat as size 2.
- wdata is passed unshifted; the masters place bytes on their natural lanes.

Timing and boundaries:
- addr_ok and data_ok are never 1 in the same cycle for the same port.
- Minimum read latency: IDLE grant → RD_ADDR (arready same cycle) → RD_DATA → data_ok. That is 2 cycles after addr_ok, with zero-wait slaves.
- Back-to-back accesses: IDLE is entered for at least one cycle between transactions. A request held during data_ok is granted in the next cycle.
- Simultaneous inst_req and data_req in IDLE: data wins. inst is served on the next IDLE cycle if inst_req is still high.
- rvalid or bvalid outside RD_DATA/WR_RESP: ignored (no ready asserted).
- Reset mid-transaction: FSM returns to IDLE and valids drop. The top level must reset the AXI slave in the same cycle.
- Request inputs may change after addr_ok; only latched values drive AXI.

Test Plan:
- Inst read, zero-wait slave: inst_req=1, addr=0xBFC00000 → inst_addr_ok in cycle 0, araddr=0xBFC00000, arsize=3'b010, arid=0; rdata=0x3C080001 → inst_data_ok=1 and inst_rdata=0x3C080001 in cycle 2.
- Contention: inst_req and data_req both high, data read of 0x80001000 → data_addr_ok first, arid=1; inst_addr_ok only after data_data_ok.
- Byte store: data_wr=1, size=0, addr=0x80000003, wdata=0xAA000000 → awaddr=0x80000003, awsize=0, wstrb=4'b1000; data_data_ok pulses only after bvalid.
- Write handshake orders: wready 3 cycles before awready, then reversed, then same cycle → exactly one AW and one W beat each time, wvalid/awvalid drop after their own ready, exactly one data_data_ok.
- Slave stalls: arready delayed 5 cycles, rvalid delayed 4 → arvalid held stable with araddr unchanged; no extra addr_ok while busy.
- Reset mid-read: rst=0 while in RD_DATA → next cycle all outputs are 0 and state is IDLE; a new request after rst=1 is granted normally.
